// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART transmit path.
//   - uart_state_e : frame FSM state encoding
//   - IDLE_LVL     : line level while idle and for stop bits (mark)
//   - START_LVL    : line level of the start bit (space)
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } uart_state_e;

  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;

endpackage

// File: rtl/uart_tx_frame.sv
// -----------------------------------------------------------------------------
// uart_tx_frame
//   UART transmitter that also requests bit timing from a shared, external baud
//   tick generator. A byte is accepted over a valid/ready handshake, bps_start is
//   raised for the whole frame, and each clk_bps pulse advances the line through
//   start, data (LSB first), optional parity and stop bits.
//
//   Optional feature macro: UART_TX_PARITY_EN
//     defined   : a parity bit follows the data bits (even, or odd if PARITY_ODD)
//     undefined : no parity state or logic; data goes straight to stop
//
//   Handshake: a byte transfers on any rising clk edge where tx_valid and
//   tx_ready are both high. tx_ready depends only on en, rst_n and the state,
//   never on tx_valid; tx_data is captured on that edge and later changes to it
//   do not affect the frame in flight.
//
// Parameters
//   DATA_BITS   data bits per frame (5..8)
//   STOP_BITS   stop bits (1 or 2)
//   PARITY_ODD  0 = even, 1 = odd parity (only with UART_TX_PARITY_EN)
//
// Ports
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset
//   en         in   global enable; low forces idle and aborts a frame
//   tx_data    in   byte to send, sampled on handshake
//   tx_valid   in   byte available
//   tx_ready   out  can accept a byte (en & idle & not in reset)
//   bps_start  out  timing request to the tick generator, high for the frame
//   clk_bps    in   one-cycle bit tick from the generator
//   txd        out  serial line, idle high
//   busy       out  frame in progress
//   state_dbg  out  current FSM state, for observation
// -----------------------------------------------------------------------------
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 bps_start,
  input  logic                 clk_bps,
  output logic                 txd,
  output logic                 busy,
  output uart_state_e          state_dbg
);

  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_BITS);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  // stop_cnt counts completed stop periods; 1 bit covers STOP_BITS of 1 or 2
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  uart_state_e          state_q, state_n;
  logic [DATA_BITS-1:0] shreg_q, shreg_n;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_n;
  logic                 stop_cnt_q, stop_cnt_n;
  logic                 txd_q, txd_n;
  logic                 bps_q, bps_n;
  logic                 busy_q, busy_n;
  logic                 handshake;

`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_n;
`else
  logic                 unused_parity_cfg;
  assign unused_parity_cfg = (PARITY_ODD != 0);
`endif

  assign tx_ready  = en & rst_n & (state_q == IDLE);
  assign handshake = tx_valid & tx_ready;
  assign txd       = txd_q;
  assign bps_start = bps_q;
  assign busy      = busy_q;
  assign state_dbg = state_q;

  always_comb begin
    state_n    = state_q;
    shreg_n    = shreg_q;
    bit_cnt_n  = bit_cnt_q;
    stop_cnt_n = stop_cnt_q;
    txd_n      = txd_q;
    bps_n      = bps_q;
`ifdef UART_TX_PARITY_EN
    par_n      = par_q;
`endif

    case (state_q)
      IDLE: begin
        // A tick landing here (or on the handshake edge) is deliberately unused.
        txd_n = IDLE_LVL;
        if (handshake) begin
          shreg_n    = tx_data;
          bit_cnt_n  = '0;
          stop_cnt_n = 1'b0;
          bps_n      = 1'b1;
`ifdef UART_TX_PARITY_EN
          par_n      = (PARITY_ODD != 0) ? ~^tx_data : ^tx_data;
`endif
          state_n    = ARM;
        end
      end

      ARM: begin
        // First tick after bps_start rises is a half period: it only aligns
        // the frame, so the start bit begins here.
        txd_n = IDLE_LVL;
        if (clk_bps) begin
          txd_n   = START_LVL;
          state_n = START;
        end
      end

      START: begin
        if (clk_bps) begin
          txd_n     = shreg_q[0];
          shreg_n   = shreg_q >> 1;
          bit_cnt_n = CNT_ONE;
          state_n   = DATA;
        end
      end

      DATA: begin
        if (clk_bps) begin
          if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            txd_n   = par_q;
            state_n = PARITY;
`else
            txd_n      = IDLE_LVL;
            stop_cnt_n = 1'b0;
            state_n    = STOP;
`endif
          end else begin
            txd_n     = shreg_q[0];
            shreg_n   = shreg_q >> 1;
            bit_cnt_n = bit_cnt_q + CNT_ONE;
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (clk_bps) begin
          txd_n      = IDLE_LVL;
          stop_cnt_n = 1'b0;
          state_n    = STOP;
        end
      end
`endif

      STOP: begin
        txd_n = IDLE_LVL;
        if (clk_bps) begin
          if (stop_cnt_q == STOP_LAST) begin
            // Dropping bps_start for at least one clk lets the generator re-phase.
            bps_n   = 1'b0;
            state_n = IDLE;
          end else begin
            stop_cnt_n = 1'b1;
          end
        end
      end

      default: begin
        txd_n   = IDLE_LVL;
        bps_n   = 1'b0;
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  // en=0 shares the reset path so it also wins over a coincident clk_bps.
  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      txd_q      <= IDLE_LVL;
      bps_q      <= 1'b0;
      busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_n;
      shreg_q    <= shreg_n;
      bit_cnt_q  <= bit_cnt_n;
      stop_cnt_q <= stop_cnt_n;
      txd_q      <= txd_n;
      bps_q      <= bps_n;
      busy_q     <= busy_n;
`ifdef UART_TX_PARITY_EN
      par_q      <= par_n;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_frame
//   Directed bench for uart_tx_frame. dut1 uses 8 data / 1 stop, dut2 uses
//   7 data / 2 stop. A local tick model stands in for the baud generator: first
//   tick a half period (8 clk) after bps_start rises, then every 16 clk.
//   Expected line levels after each tick are queued by the stimulus; monitors
//   pop and compare on every tick the DUT acts on.
// -----------------------------------------------------------------------------
module tb_uart_tx_frame;
  import uart_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic en, en2;

  // ---------------- dut1: 8 data, 1 stop ----------------
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready, bps_start, txd, busy, clk_bps;
  logic        gen_tick = 1'b0, inj_tick;
  uart_state_e state_dbg;

  uart_tx_frame #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .bps_start(bps_start), .clk_bps(clk_bps), .txd(txd),
    .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- dut2: 7 data, 2 stop ----------------
  logic [6:0]  tx_data2;
  logic        tx_valid2, tx_ready2, bps_start2, txd2, busy2, clk_bps2;
  logic        gen_tick2 = 1'b0;
  uart_state_e state_dbg2;

  uart_tx_frame #(.DATA_BITS(7), .STOP_BITS(2), .PARITY_ODD(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_ready(tx_ready2), .bps_start(bps_start2), .clk_bps(clk_bps2), .txd(txd2),
    .busy(busy2), .state_dbg(state_dbg2)
  );

  // ---------------- tick models ----------------
  int   g1_cnt = 0, g2_cnt = 0;
  logic g1_first = 1'b1, g2_first = 1'b1;

  always @(posedge clk) begin
    if (bps_start !== 1'b1) begin
      g1_cnt <= 0; g1_first <= 1'b1; gen_tick <= 1'b0;
    end else if ((g1_first && g1_cnt == 7) || (!g1_first && g1_cnt == 15)) begin
      gen_tick <= 1'b1; g1_cnt <= 0; g1_first <= 1'b0;
    end else begin
      gen_tick <= 1'b0; g1_cnt <= g1_cnt + 1;
    end
  end

  always @(posedge clk) begin
    if (bps_start2 !== 1'b1) begin
      g2_cnt <= 0; g2_first <= 1'b1; gen_tick2 <= 1'b0;
    end else if ((g2_first && g2_cnt == 7) || (!g2_first && g2_cnt == 15)) begin
      gen_tick2 <= 1'b1; g2_cnt <= 0; g2_first <= 1'b0;
    end else begin
      gen_tick2 <= 1'b0; g2_cnt <= g2_cnt + 1;
    end
  end

  assign clk_bps  = gen_tick | inj_tick;
  assign clk_bps2 = gen_tick2;

  // ---------------- scoreboard ----------------
  logic [0:0] exp_q[$];
  logic [0:0] exp_q2[$];
  int n_cmp = 0;
  int n_err = 0;
  int tick_cnt1 = 0, tick_cnt2 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input string s, input int which);
    for (int i = 0; i < s.len(); i++) begin
      logic [0:0] b;
      b = (s[i] == 8'h31) ? 1'b1 : 1'b0;
      if (which == 1) exp_q.push_back(b);
      else            exp_q2.push_back(b);
    end
  endtask

  // Monitors: on every tick the DUT acts on, the line level one clk later
  // must equal the next queued expectation.
  always @(posedge clk) begin
    if (rst_n === 1'b1 && en === 1'b1 && clk_bps === 1'b1) begin
      @(negedge clk);
      tick_cnt1++;
      if (exp_q.size() == 0) begin
        check("txd_unexpected_tick", 32'(txd), 32'hx);
      end else begin
        logic [0:0] e;
        e = exp_q.pop_front();
        check("txd", 32'(txd), 32'(e));
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n === 1'b1 && en2 === 1'b1 && clk_bps2 === 1'b1) begin
      @(negedge clk);
      tick_cnt2++;
      if (exp_q2.size() == 0) begin
        check("txd2_unexpected_tick", 32'(txd2), 32'hx);
      end else begin
        logic [0:0] e;
        e = exp_q2.pop_front();
        check("txd2", 32'(txd2), 32'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send1(input logic [7:0] d);
    bit done;
    done = 1'b0;
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk);
      if (tx_ready === 1'b1) done = 1'b1;
    end
    #1 tx_valid = 1'b0;
    if (!done) check("send1_timeout", 32'(0), 32'(1));
  endtask

  task automatic send2(input logic [6:0] d);
    bit done;
    done = 1'b0;
    @(negedge clk);
    tx_data2  = d;
    tx_valid2 = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk);
      if (tx_ready2 === 1'b1) done = 1'b1;
    end
    #1 tx_valid2 = 1'b0;
    if (!done) check("send2_timeout", 32'(0), 32'(1));
  endtask

  // Waits until the chosen queue holds at most n entries; a timeout is a failure.
  task automatic wait_q(input int which, input int n);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      @(negedge clk);
      #1;
      if (which == 1 && exp_q.size() <= n)  done = 1'b1;
      if (which == 2 && exp_q2.size() <= n) done = 1'b1;
    end
    if (!done) check("wait_q_timeout", 32'(0), 32'(1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    int gap;
    bit done;

    rst_n = 1'b0; en = 1'b1; en2 = 1'b1;
    tx_valid = 1'b0; tx_data = '0; inj_tick = 1'b0;
    tx_valid2 = 1'b0; tx_data2 = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_txd", 32'(txd), 32'(1));
    check("rst_bps_start", 32'(bps_start), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_tx_ready", 32'(tx_ready), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_tx_ready", 32'(tx_ready), 32'(1));
    check("post_rst_state", 32'(state_dbg), 32'(IDLE));

    // 1: 0x55
`ifdef UART_TX_PARITY_EN
    push_frame("010101010011", 1);
`else
    push_frame("01010101011", 1);
`endif
    send1(8'h55);
    wait_q(1, 1);
    check("t1_busy_before_stop_tick", 32'(busy), 32'(1));
    wait_q(1, 0);
    check("t1_busy_after_stop_tick", 32'(busy), 32'(0));
    check("t1_ready_after_stop_tick", 32'(tx_ready), 32'(1));

    // 2: 0xA3, parity bit 0 (four ones, even parity) when enabled
`ifdef UART_TX_PARITY_EN
    push_frame("011000101011", 1);
`else
    push_frame("01100010111", 1);
`endif
    send1(8'hA3);
    wait_q(1, 0);

    // 3: 0x00 then tx_valid held with 0xFF
`ifdef UART_TX_PARITY_EN
    push_frame("000000000011", 1);
    push_frame("011111111011", 1);
`else
    push_frame("00000000011", 1);
    push_frame("01111111111", 1);
`endif
    @(negedge clk);
    tx_data = 8'h00; tx_valid = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk);
      if (tx_ready === 1'b1) done = 1'b1;
    end
    #1 tx_data = 8'hFF;
    if (!done) check("t3_hs1_timeout", 32'(0), 32'(1));
    gap = 0; done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (bps_start === 1'b0) gap++;
      if (tx_ready === 1'b1) done = 1'b1;
    end
    if (!done) check("t3_idle_timeout", 32'(0), 32'(1));
    @(negedge clk);
    tx_valid = 1'b0;
    check("t3_bps_start_regained", 32'(bps_start), 32'(1));
    check("t3_bps_start_gap", 32'(gap), 32'(1));
    wait_q(1, 0);

    // 4: reset during data bit 4 of 0xA5 (bit 4 is 0), then 0x3C
`ifdef UART_TX_PARITY_EN
    push_frame("010100101011", 1);
`else
    push_frame("01010010111", 1);
`endif
    base = tick_cnt1;
    send1(8'hA5);
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      #1;
      if (tick_cnt1 >= base + 6) done = 1'b1;
    end
    if (!done) check("t4_tick_timeout", 32'(0), 32'(1));
    repeat (3) @(negedge clk);
    check("t4_txd_bit4_before_rst", 32'(txd), 32'(0));
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("t4_rst_txd", 32'(txd), 32'(1));
    check("t4_rst_bps_start", 32'(bps_start), 32'(0));
    check("t4_rst_busy", 32'(busy), 32'(0));
    check("t4_rst_tx_ready", 32'(tx_ready), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("t4_release_tx_ready", 32'(tx_ready), 32'(1));
`ifdef UART_TX_PARITY_EN
    push_frame("000111100011", 1);
`else
    push_frame("00011110011", 1);
`endif
    send1(8'h3C);
    wait_q(1, 0);

    // 5: en=0 in ARM coincident with a tick
    send1(8'h5A);
    check("t5_state_arm", 32'(state_dbg), 32'(ARM));
    @(negedge clk);
    en = 1'b0; inj_tick = 1'b1;
    @(negedge clk);
    inj_tick = 1'b0;
    check("t5_txd_no_start", 32'(txd), 32'(1));
    check("t5_bps_start", 32'(bps_start), 32'(0));
    check("t5_busy", 32'(busy), 32'(0));
    check("t5_state_idle", 32'(state_dbg), 32'(IDLE));
    check("t5_tx_ready_en0", 32'(tx_ready), 32'(0));
    repeat (3) @(negedge clk);
    check("t5_tx_ready_still0", 32'(tx_ready), 32'(0));
    en = 1'b1;
    #1;
    check("t5_tx_ready_en1", 32'(tx_ready), 32'(1));
    repeat (40) @(negedge clk);
    check("t5_txd_idle", 32'(txd), 32'(1));

    // 6: dut2, 7 data + 2 stop, 0x7F
    base = tick_cnt2;
`ifdef UART_TX_PARITY_EN
    push_frame("011111111111", 2);
`else
    push_frame("01111111111", 2);
`endif
    send2(7'h7F);
    wait_q(2, 0);
    check("t6_busy_end", 32'(busy2), 32'(0));
`ifdef UART_TX_PARITY_EN
    check("t6_frame_ticks", 32'(tick_cnt2 - base), 32'(12));
`else
    check("t6_frame_ticks", 32'(tick_cnt2 - base), 32'(11));
`endif

    repeat (20) @(negedge clk);
    check("final_q1_drained", 32'(exp_q.size()), 32'(0));
    check("final_q2_drained", 32'(exp_q2.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
